mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port 32-bit SRAM macro between the core's instruction-fetch port (read-only) and data port (read/write).
- Sits between the CPU's IM_*/DM_* style ports and a unified SRAM. Issues at most one SRAM access per cycle.
- Data port has priority. A starvation counter forces an instruction grant after a bounded wait.
- Read data is returned one cycle after issue, tagged to the issuing port.

Parameters:
- ADDR_W, 14, word-address width of all address ports.
- MAX_WAIT, 3, consecutive denied cycles after which a pending instruction request overrides data priority. Legal range 1..15.
- CNT_W, 4, width of the starvation counter. Must hold MAX_WAIT.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- i_req  input  1  instruction read request. Held with i_addr stable until i_gnt.
- i_addr  input  ADDR_W  instruction word address.
- i_gnt  output  1  combinational grant; transfer occurs in the cycle where i_req && i_gnt.
- i_rvalid  output  1  instruction read data valid; asserted the cycle after the grant.
- i_rdata  output  32  instruction read data.
- d_req  input  1  data request. Held with d_addr/d_web/d_wdata stable until d_gnt.
- d_addr  input  ADDR_W  data word address.
- d_web  input  4  byte write enables, active low; 4'b1111 means read.
- d_wdata  input  32  store data, already byte-lane aligned.
- d_gnt  output  1  combinational data grant.
- d_rvalid  output  1  data read data valid; asserted the cycle after a granted read.
- d_rdata  output  32  data read data.
- SRAM_CS  output  1  chip select.
- SRAM_OE  output  1  output enable, high during the response cycle of a read.
- SRAM_WEB  output  4  active-low byte write enables.
- SRAM_A  output  ADDR_W  address.
- SRAM_DI  output  32  write data.
- SRAM_DO  input  32  read data, valid the cycle after the read is issued.

Behaviour:
- **Arbitration** (combinational, every cycle):
  - only i_req: grant I.
  - only d_req: grant D.
  - both: grant I if starve_cnt >= MAX_WAIT, else grant D.
  - neither: no grant, SRAM_CS=0.
  - i_gnt and d_gnt are never high together.
- **SRAM drive on grant:** SRAM_CS=1 and SRAM_A=granted address.
  - SRAM_WEB = d_web for a D grant, 4'b1111 for an I grant.
  - SRAM_DI = d_wdata for a D grant, else 0.
  - With no grant: SRAM_WEB=4'b1111, SRAM_A=0.
- **Response FSM**, registered state resp_st:
  - States: R_NONE, R_INST, R_DATA.
  - Next state: R_INST on an I grant; R_DATA on a D grant with d_web==4'b1111; otherwise R_NONE (including writes).
  - In R_INST: i_rvalid=1, i_rdata=SRAM_DO, SRAM_OE=1.
  - In R_DATA: d_rvalid=1, d_rdata=SRAM_DO, SRAM_OE=1.
  - In R_NONE: both rvalids 0, rdata=0, SRAM_OE=0.
  - A new grant may be issued in the same cycle as a response; back-to-back reads give 1 access per cycle.
- **Latency:** grant cycle N → rvalid in cycle N+1. Writes complete in the grant cycle and produce no response.
- **Starvation counter starve_cnt:**
  - If i_req && !i_gnt: increment, saturating at MAX_WAIT.
  - If i_gnt or !i_req: clear to 0.
- **Reset:** resp_st=R_NONE, starve_cnt=0. All outputs low except SRAM_WEB=4'b1111. A grant that is live in the reset cycle is discarded and no rvalid follows.
- **Boundaries:**
  - A requester dropping req without a grant is legal; no side effects.
  - A simultaneous D write and I read gives the data write first. The I read then proceeds at most MAX_WAIT cycles later.
  - Address values of ports without a grant are ignored.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined:
  - adds outputs perf_conflict (32-bit) and perf_override (32-bit), both synchronously reset to 0.
  - perf_conflict counts cycles with i_req && d_req.
  - perf_override counts cycles where starvation forced an I grant over a pending D request.
  - Both saturate at 32'hFFFF_FFFF.
- When undefined: those ports and counters do not exist. Arbitration is unaffected either way.

Test Plan:
- Reset: hold rst 2 cycles with i_req=1 → i_gnt=0, SRAM_CS=0, SRAM_WEB=4'hF. First grant in the cycle after rst falls; i_rvalid one cycle later.
- Instruction only: i_req=1, i_addr=0x0004 for 3 cycles, SRAM_DO returns 0x00000013 → i_gnt=1 every cycle, i_rvalid=1 in cycles 2..4 with i_rdata=0x00000013.
- Data write: d_req=1, d_addr=0x0010, d_web=4'b1110, d_wdata=0x000000AB → d_gnt=1, SRAM_WEB=4'b1110, SRAM_DI=0x000000AB, no d_rvalid next cycle.
- Data priority: i_req and d_req both high, d_web=4'hF → D granted first; d_rvalid the next cycle with d_rdata=SRAM_DO.
- Starvation: d_req held high with continuous reads, i_req high, MAX_WAIT=3 → D granted 3 cycles; I granted in cycle 4; starve_cnt back to 0. With ARB_PERF_CNT_EN, perf_override=1 and perf_conflict=4.
- Reset mid-operation: I granted in cycle N, rst=1 in cycle N+1 → i_rvalid=0 in N+1, resp_st=R_NONE, starve_cnt=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between an instruction-fetch port and a data port.
// Optional performance counters are enabled by defining ARB_PERF_CNT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int MAX_WAIT = 3,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_web,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              SRAM_CS,
  output logic              SRAM_OE,
  output logic [3:0]        SRAM_WEB,
  output logic [ADDR_W-1:0] SRAM_A,
  output logic [31:0]       SRAM_DI,
  input  logic [31:0]       SRAM_DO
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_conflict,
  output logic [31:0]       perf_override
`endif
);

  typedef enum logic [1:0] {
    R_NONE = 2'd0,
    R_INST = 2'd1,
    R_DATA = 2'd2
  } resp_e;

  localparam logic [CNT_W-1:0] MaxWaitC = CNT_W'(MAX_WAIT);

  resp_e            resp_st_q, resp_st_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             starved;
  logic             gnt_i, gnt_d;

  // Grants are suppressed while reset is high so nothing issued then can respond.
  always_comb begin
    starved = (starve_cnt_q >= MaxWaitC);
    gnt_i   = 1'b0;
    gnt_d   = 1'b0;
    if (!rst) begin
      if (i_req && (!d_req || starved)) begin
        gnt_i = 1'b1;
      end else if (d_req) begin
        gnt_d = 1'b1;
      end
    end
  end

  assign i_gnt = gnt_i;
  assign d_gnt = gnt_d;

  always_comb begin
    SRAM_CS  = 1'b0;
    SRAM_WEB = 4'hF;
    SRAM_A   = '0;
    SRAM_DI  = '0;
    if (gnt_i) begin
      SRAM_CS = 1'b1;
      SRAM_A  = i_addr;
    end else if (gnt_d) begin
      SRAM_CS  = 1'b1;
      SRAM_A   = d_addr;
      SRAM_WEB = d_web;
      SRAM_DI  = d_wdata;
    end
  end

  // Writes finish in the grant cycle, so only reads schedule a response.
  always_comb begin
    resp_st_d = R_NONE;
    if (gnt_i) begin
      resp_st_d = R_INST;
    end else if (gnt_d && (d_web == 4'hF)) begin
      resp_st_d = R_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_st_q <= R_NONE;
    end else begin
      resp_st_q <= resp_st_d;
    end
  end

  always_comb begin
    i_rvalid = 1'b0;
    i_rdata  = '0;
    d_rvalid = 1'b0;
    d_rdata  = '0;
    SRAM_OE  = 1'b0;
    if (!rst) begin
      case (resp_st_q)
        R_INST: begin
          i_rvalid = 1'b1;
          i_rdata  = SRAM_DO;
          SRAM_OE  = 1'b1;
        end
        R_DATA: begin
          d_rvalid = 1'b1;
          d_rdata  = SRAM_DO;
          SRAM_OE  = 1'b1;
        end
        default: begin
          i_rvalid = 1'b0;
        end
      endcase
    end
  end

  // Counts consecutive cycles a pending fetch was denied, saturating at the limit.
  always_comb begin
    starve_cnt_d = '0;
    if (i_req && !gnt_i) begin
      starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_conflict_q, perf_conflict_d;
  logic [31:0] perf_override_q, perf_override_d;

  always_comb begin
    perf_conflict_d = perf_conflict_q;
    perf_override_d = perf_override_q;
    if (i_req && d_req && (perf_conflict_q != 32'hFFFF_FFFF)) begin
      perf_conflict_d = perf_conflict_q + 32'd1;
    end
    if (gnt_i && d_req && (perf_override_q != 32'hFFFF_FFFF)) begin
      perf_override_d = perf_override_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflict_q <= '0;
      perf_override_q <= '0;
    end else begin
      perf_conflict_q <= perf_conflict_d;
      perf_override_q <= perf_override_d;
    end
  end

  assign perf_conflict = perf_conflict_q;
  assign perf_override = perf_override_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a behavioural SRAM and reference model.
// Define ARB_PERF_CNT_EN to also check the performance counters.
module tb_mem_port_arbiter;
  localparam int ADDR_W   = 14;
  localparam int MAX_WAIT = 3;
  localparam int CNT_W    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt, i_rvalid;
  logic [31:0]       i_rdata;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [3:0]        d_web;
  logic [31:0]       d_wdata;
  logic              d_gnt, d_rvalid;
  logic [31:0]       d_rdata;
  logic              SRAM_CS, SRAM_OE;
  logic [3:0]        SRAM_WEB;
  logic [ADDR_W-1:0] SRAM_A;
  logic [31:0]       SRAM_DI;
  logic [31:0]       SRAM_DO;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]       perf_conflict, perf_override;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_web(d_web), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .SRAM_CS(SRAM_CS), .SRAM_OE(SRAM_OE), .SRAM_WEB(SRAM_WEB), .SRAM_A(SRAM_A),
    .SRAM_DI(SRAM_DI), .SRAM_DO(SRAM_DO)
`ifdef ARB_PERF_CNT_EN
    , .perf_conflict(perf_conflict), .perf_override(perf_override)
`endif
  );

  typedef struct {
    bit          isInst;
    logic [31:0] data;
    int          due;
  } resp_t;

  resp_t       expQ[$];
  logic [31:0] mem    [0:255];
  logic [31:0] shadow [0:255];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          waitCnt = 0;
  bit          mGntI = 0;
  bit          mGntD = 0;
  logic [31:0] mConf = '0;
  logic [31:0] mOvr  = '0;

  // Behavioural SRAM: byte-masked writes, read data registered for the next cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (SRAM_CS) begin
      if (SRAM_WEB == 4'hF) begin
        SRAM_DO <= mem[SRAM_A[7:0]];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (!SRAM_WEB[b]) mem[SRAM_A[7:0]][8*b +: 8] <= SRAM_DI[8*b +: 8];
        end
      end
    end
  end

  task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: arbitration rules applied to the sampled requests each cycle.
  task automatic checkOutput();
    bit          eI, eD;
    logic [7:0]  ia, da;
    eI = !rst && i_req && (!d_req || waitCnt >= MAX_WAIT);
    eD = !rst && d_req && !eI;
    ia = i_addr[7:0];
    da = d_addr[7:0];
    compareValue("i_gnt", 32'(i_gnt), 32'(eI));
    compareValue("d_gnt", 32'(d_gnt), 32'(eD));
    compareValue("SRAM_CS", 32'(SRAM_CS), 32'(eI || eD));
    compareValue("SRAM_WEB", 32'(SRAM_WEB), eD ? 32'(d_web) : 32'hF);
    compareValue("SRAM_A", 32'(SRAM_A), eI ? 32'(i_addr) : (eD ? 32'(d_addr) : 32'h0));
    compareValue("SRAM_DI", SRAM_DI, eD ? d_wdata : 32'h0);
`ifdef ARB_PERF_CNT_EN
    compareValue("perf_conflict", perf_conflict, mConf);
    compareValue("perf_override", perf_override, mOvr);
    if (rst) begin
      mConf = '0;
      mOvr  = '0;
    end else begin
      if (i_req && d_req) mConf = mConf + 1;
      if (eI && d_req)    mOvr  = mOvr + 1;
    end
`endif
    if (eI) expQ.push_back('{1'b1, shadow[ia], cyc + 1});
    if (eD) begin
      if (d_web == 4'hF) begin
        expQ.push_back('{1'b0, shadow[da], cyc + 1});
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (!d_web[b]) shadow[da][8*b +: 8] = d_wdata[8*b +: 8];
        end
      end
    end
    if (rst) waitCnt = 0;
    else if (i_req && !eI) waitCnt = (waitCnt + 1 > MAX_WAIT) ? MAX_WAIT : waitCnt + 1;
    else waitCnt = 0;
    mGntI = eI;
    mGntD = eD;
  endtask

  always @(negedge clk) checkOutput();

  // Monitor: pops the scoreboard whenever a response is due or presented.
  always @(negedge clk) begin
    bit    haveExp;
    resp_t e;
    haveExp = (expQ.size() > 0) && (expQ[0].due == cyc);
    compareValue("SRAM_OE", 32'(SRAM_OE), 32'(haveExp && !rst));
    if (!i_rvalid) compareValue("i_rdata_idle", i_rdata, 32'h0);
    if (!d_rvalid) compareValue("d_rdata_idle", d_rdata, 32'h0);
    if (rst) begin
      if (haveExp) void'(expQ.pop_front());
      compareValue("rvalid_in_reset", {30'h0, i_rvalid, d_rvalid}, 32'h0);
    end else if (i_rvalid || d_rvalid) begin
      if (!haveExp) begin
        compareValue("unexpected_rvalid", {30'h0, i_rvalid, d_rvalid}, 32'h0);
      end else begin
        e = expQ.pop_front();
        compareValue("rvalid_port", {30'h0, i_rvalid, d_rvalid}, e.isInst ? 32'h2 : 32'h1);
        compareValue("rdata", e.isInst ? i_rdata : d_rdata, e.data);
      end
    end else if (haveExp) begin
      e = expQ.pop_front();
      compareValue("missing_rvalid", 32'h0, e.isInst ? 32'h2 : 32'h1);
    end
  end

  // Random traffic: requests are held until granted, occasionally withdrawn.
  task automatic applyStimulus(input bit allowReset);
    if (!i_req || mGntI) begin
      i_req  = ($urandom_range(0, 3) != 0);
      i_addr = ADDR_W'($urandom_range(0, 255));
    end else if ($urandom_range(0, 15) == 0) begin
      i_req = 1'b0;
    end
    if (!d_req || mGntD) begin
      d_req   = ($urandom_range(0, 1) == 1);
      d_addr  = ADDR_W'($urandom_range(0, 255));
      d_web   = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 14));
      d_wdata = $urandom;
    end else if ($urandom_range(0, 15) == 0) begin
      d_req = 1'b0;
    end
    rst = allowReset && ($urandom_range(0, 99) == 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = $urandom;
      shadow[i] = mem[i];
    end
    rst = 1'b1; i_req = 1'b1; i_addr = ADDR_W'(4);
    d_req = 1'b0; d_addr = '0; d_web = 4'hF; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 i_req = 1'b0; d_req = 1'b1; d_addr = ADDR_W'(16); d_web = 4'b1110; d_wdata = 32'h0000_00AB;
    @(posedge clk);
    #1 d_req = 1'b0;
    @(posedge clk);
    #1 i_req = 1'b1; i_addr = ADDR_W'(8); d_req = 1'b1; d_web = 4'hF; d_addr = ADDR_W'(16);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1 d_addr = ADDR_W'($urandom_range(0, 255));
      if (mGntI) i_addr = ADDR_W'($urandom_range(0, 255));
    end
    i_req = 1'b1; d_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1; i_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1 applyStimulus(1'b1);
    end
    @(posedge clk);
    #1 rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
